// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: memory request/response, redirect and core-side instruction handshake.
// master = fetch unit side, slave = memory/core environment side.
interface fetch_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests to an in-order memory, a {pc, word}
// FIFO toward the core, and redirect with flush of buffered and in-flight fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // producer's valid never depends on the consumer's ready. mem_rsp has no ready.

    logic [31:0]   fetch_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] tag_rd;
    logic [AW-1:0] tag_wr;
    logic [CW-1:0] count;
    logic [CW-1:0] live;
    logic [CW-1:0] drop;
    logic [31:0]   hold_word;
    logic [31:0]   hold_pc;

    logic [31:0]   fifo_word [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   tag_pc    [DEPTH];

    logic [CW:0]   credit_used;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [1:0]    unused_redirect_lsb;

    assign unused_redirect_lsb = bus.redirect_pc[1:0];

    // Credit covers buffered words plus live requests, so every kept response has a slot.
    assign credit_used = {1'b0, count} + {1'b0, live};
    assign req_valid   = !rst && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign req_fire    = req_valid && bus.mem_req_ready;

    assign rsp_drop    = bus.mem_rsp_valid && (drop != '0);
    assign rsp_keep    = bus.mem_rsp_valid && (drop == '0) && (live != '0);
    assign push        = rsp_keep && !bus.redirect_valid;
    assign fifo_empty  = (count == '0);
    assign pop         = !fifo_empty && bus.instr_ready && !bus.redirect_valid;

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.instr_valid   = !fifo_empty;
    assign bus.instr         = fifo_empty ? hold_word : fifo_word[rd_ptr];
    assign bus.instr_pc      = fifo_empty ? hold_pc   : fifo_pc[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            tag_rd    <= '0;
            tag_wr    <= '0;
            count     <= '0;
            live      <= '0;
            drop      <= '0;
            hold_word <= '0;
            hold_pc   <= '0;
        end else begin
            // Remember the head being shown so the outputs stay put once the FIFO drains.
            if (!fifo_empty) begin
                hold_word <= fifo_word[rd_ptr];
                hold_pc   <= fifo_pc[rd_ptr];
            end

            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                tag_rd   <= '0;
                tag_wr   <= '0;
                count    <= '0;
                live     <= '0;
                // Every outstanding request becomes stale; a response arriving now retires one.
                drop     <= drop + live - CW'(rsp_drop || rsp_keep);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    tag_wr   <= tag_wr + AW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    tag_rd <= tag_rd + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (rsp_drop) begin
                    drop <= drop - CW'(1);
                end
                live  <= live + CW'(req_fire) - CW'(rsp_keep);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays carry no reset; only entries covered by the counters are ever read.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
        if (push) begin
            fifo_word[wr_ptr] <= bus.mem_rsp_data;
            fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order variable-latency memory model, delivery monitor,
// and one task per scenario with inline comparisons against hand-derived values.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0040_0000), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_total = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit toggle_ready = 1'b0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Memory model: drives at negedge+1, samples acceptances at negedge+2.
    initial begin
        mreq_t m;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                mq.delete();
                bus.mem_req_ready = 1'b0;
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = '0;
            end else begin
                bus.mem_req_ready = toggle_ready ? cyc[0] : 1'b1;
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_word(mq[0].addr);
                    void'(mq.pop_front());
                end else begin
                    bus.mem_rsp_valid = 1'b0;
                    bus.mem_rsp_data  = '0;
                end
            end
            #1;
            if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
                m.addr = bus.mem_req_addr;
                m.due  = cyc + int'($urandom_range(lat_max, lat_min));
                mq.push_back(m);
                acc_total++;
            end
        end
    end

    // Delivery monitor: records every pop that will take effect at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst && bus.instr_valid && bus.instr_ready && !bus.redirect_valid)
                got_q.push_back({bus.instr_pc, bus.instr});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #3;
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", bus.mem_req_valid); end
        checks++; if (bus.mem_req_addr !== 32'h0040_0000) begin errors++; $display("FAIL reset_req_addr got %h exp 00400000", bus.mem_req_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b exp 0", bus.instr_valid); end
        checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", bus.instr); end
        checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h exp 0", bus.instr_pc); end
        @(negedge clk);
        rst = 1'b0;
        #3;
        checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid got %b exp 1", bus.mem_req_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        lat_min = 1; lat_max = 1; toggle_ready = 1'b0;
        do_reset();
        bus.instr_ready = 1'b1;
        #3;
        checks++; if (bus.mem_req_addr !== 32'h0040_0000) begin errors++; $display("FAIL stream_first_addr got %h exp 00400000", bus.mem_req_addr); end
        @(negedge clk); #3;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", bus.instr_valid); end
        checks++; if (bus.mem_req_addr !== 32'h0040_0004) begin errors++; $display("FAIL stream_second_addr got %h exp 00400004", bus.mem_req_addr); end
        @(negedge clk); #3;
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid got %b exp 1", bus.instr_valid); end
        checks++; if (bus.instr !== mem_word(32'h0040_0000)) begin errors++; $display("FAIL stream_first_word got %h exp %h", bus.instr, mem_word(32'h0040_0000)); end
        for (int k = 0; k < 6; k++) begin
            exp_pc = 32'h0040_0000 + 32'(4 * k);
            checks++;
            if ({bus.instr_valid, bus.instr_pc} !== {1'b1, exp_pc}) begin
                errors++; $display("FAIL stream_pc[%0d] got valid %b pc %h exp valid 1 pc %h", k, bus.instr_valid, bus.instr_pc, exp_pc);
            end
            @(negedge clk); #3;
        end
    endtask

    task automatic test_stall();
        int base;
        lat_min = 1; lat_max = 1; toggle_ready = 1'b0;
        do_reset();
        base = acc_total;
        repeat (10) @(negedge clk);
        #3;
        checks++; if (acc_total - base !== 4) begin errors++; $display("FAIL stall_accepts got %0d exp 4", acc_total - base); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got %b exp 0", bus.mem_req_valid); end
        checks++; if (bus.instr_pc !== 32'h0040_0000) begin errors++; $display("FAIL stall_head_pc got %h exp 00400000", bus.instr_pc); end
        checks++; if (bus.instr !== mem_word(32'h0040_0000)) begin errors++; $display("FAIL stall_head_word got %h exp %h", bus.instr, mem_word(32'h0040_0000)); end
        bus.instr_ready = 1'b1;
        repeat (8) @(negedge clk);
        #3;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({32'h0040_0000 + 32'(4 * i), mem_word(32'h0040_0000 + 32'(4 * i))});
        checks++; if (got_q.size() < 4) begin errors++; $display("FAIL stall_drain_count got %0d exp >=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_drain[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_redirect();
        int base;
        lat_min = 6; lat_max = 6; toggle_ready = 1'b0;
        do_reset();
        base = acc_total;
        bus.instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0042;
        #3;
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_blocked got %b exp 0", bus.mem_req_valid); end
        checks++; if (acc_total - base !== 3) begin errors++; $display("FAIL redir_in_flight got %0d exp 3", acc_total - base); end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        got_q.delete();
        #3;
        checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL redir_req_valid got %b exp 1", bus.mem_req_valid); end
        checks++; if (bus.mem_req_addr !== 32'h0040_0040) begin errors++; $display("FAIL redir_addr got %h exp 00400040", bus.mem_req_addr); end
        repeat (20) @(negedge clk);
        #3;
        checks++; if (got_q.size() < 3) begin errors++; $display("FAIL redir_count got %0d exp >=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {32'h0040_0040 + 32'(4 * i), mem_word(32'h0040_0040 + 32'(4 * i))}) begin
                errors++; $display("FAIL redir_deliver[%0d] got %h exp pc %h", i, got_q[i], 32'h0040_0040 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_collision();
        lat_min = 2; lat_max = 2; toggle_ready = 1'b0;
        do_reset();
        bus.instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0100;
        #3;
        checks++; if ({bus.mem_rsp_valid, bus.instr_valid} !== 2'b11) begin errors++; $display("FAIL coll_setup got rsp %b valid %b exp 1 1", bus.mem_rsp_valid, bus.instr_valid); end
        checks++; if (bus.instr_pc !== 32'h0040_0000) begin errors++; $display("FAIL coll_head_pc got %h exp 00400000", bus.instr_pc); end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #3;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL coll_flushed got %b exp 0", bus.instr_valid); end
        checks++; if (bus.instr_pc !== 32'h0040_0000) begin errors++; $display("FAIL coll_hold_pc got %h exp 00400000", bus.instr_pc); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL coll_void_pop got %0d exp 0", got_q.size()); end
        checks++; if (bus.mem_req_addr !== 32'h0040_0100) begin errors++; $display("FAIL coll_addr got %h exp 00400100", bus.mem_req_addr); end
        repeat (20) @(negedge clk);
        #3;
        checks++; if (got_q.size() < 3) begin errors++; $display("FAIL coll_count got %0d exp >=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {32'h0040_0100 + 32'(4 * i), mem_word(32'h0040_0100 + 32'(4 * i))}) begin
                errors++; $display("FAIL coll_deliver[%0d] got %h exp pc %h", i, got_q[i], 32'h0040_0100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_back_to_back();
        lat_min = 4; lat_max = 4; toggle_ready = 1'b0;
        do_reset();
        bus.instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0050_0000;
        @(negedge clk);
        bus.redirect_pc    = 32'h0060_000A;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        got_q.delete();
        #3;
        checks++; if (bus.mem_req_addr !== 32'h0060_0008) begin errors++; $display("FAIL b2b_addr got %h exp 00600008", bus.mem_req_addr); end
        repeat (20) @(negedge clk);
        #3;
        checks++; if (got_q.size() < 2) begin errors++; $display("FAIL b2b_count got %0d exp >=2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {32'h0060_0008 + 32'(4 * i), mem_word(32'h0060_0008 + 32'(4 * i))}) begin
                errors++; $display("FAIL b2b_deliver[%0d] got %h exp pc %h", i, got_q[i], 32'h0060_0008 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 5; toggle_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 160; c++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        bus.instr_ready = 1'b1;
        repeat (20) @(negedge clk);
        #3;
        exp_q.delete();
        for (int i = 0; i < got_q.size(); i++) exp_q.push_back({32'h0040_0000 + 32'(4 * i), mem_word(32'h0040_0000 + 32'(4 * i))});
        checks++; if (got_q.size() < 20) begin errors++; $display("FAIL rand_count got %0d exp >=20", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_deliver[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        toggle_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        lat_min = 1; lat_max = 1; toggle_ready = 1'b0;
        do_reset();
        repeat (8) @(negedge clk);
        #3;
        checks++; if ({bus.instr_valid, bus.mem_req_valid} !== 2'b10) begin errors++; $display("FAIL areset_full got valid %b req %b exp 1 0", bus.instr_valid, bus.mem_req_valid); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL areset_instr_valid got %b exp 0", bus.instr_valid); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL areset_req_valid got %b exp 0", bus.mem_req_valid); end
        checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL areset_instr_pc got %h exp 0", bus.instr_pc); end
        checks++; if (bus.mem_req_addr !== 32'h0040_0000) begin errors++; $display("FAIL areset_addr got %h exp 00400000", bus.mem_req_addr); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        #3;
        checks++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 32'h0040_0000}) begin errors++; $display("FAIL areset_restart got valid %b addr %h exp 1 00400000", bus.mem_req_valid, bus.mem_req_addr); end
        repeat (2) @(negedge clk);
        #3;
        checks++; if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 32'h0040_0000}) begin errors++; $display("FAIL areset_first_instr got valid %b pc %h exp 1 00400000", bus.instr_valid, bus.instr_pc); end
    endtask

    initial begin
        rst                = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_collision();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
